// File: rtl/jts16_rom_pkg.sv
// Shared definitions for the System 16 graphics ROM responder: slot indices,
// arbiter state encoding and the SDRAM word-address helper.
package jts16_rom_pkg;

  localparam int CHAR  = 0;
  localparam int SCR1  = 1;
  localparam int SCR2  = 2;
  localparam int MAP1  = 3;
  localparam int MAP2  = 4;
  localparam int NSLOT = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  // Region offset plus a doubled word index; the sum wraps at 22 bits.
  function automatic logic [21:0] word_addr(input logic [21:0] offset,
                                            input logic [20:0] idx);
    return offset + {idx, 1'b0};
  endfunction

endpackage

// File: rtl/jts16_rom_slot.sv
// One-entry tagged cache for a single video fetch port. 16-bit ports share a
// 32-bit SDRAM read between the even and odd word of each pair.
module jts16_rom_slot
  import jts16_rom_pkg::*;
#(
  parameter  int AW   = 13,
  parameter  bit IS16 = 1'b0,
  localparam int DW   = IS16 ? 16 : 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          set_busy,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          ok,
  output logic          pending,
  output logic [DW-1:0] data
);

  logic          valid_q;
  logic          busy_q;
  logic [AW-1:0] tag_q;
  logic [31:0]   buf_q;

  // NOTE: the data buffer is reset too, so every data output reads 0 out of
  // reset instead of X; it is a single word, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tag_q   <= '0;
      buf_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, whatever order these statements appear in.
      if (set_busy) busy_q <= 1'b1;
      if (wr) begin
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
        tag_q   <= wr_tag;
        buf_q   <= wr_data;
      end
    end
  end

  generate
    if (IS16) begin : g_half
      assign ok   = valid_q && (tag_q[AW-1:1] == addr[AW-1:1]);
      assign data = addr[0] ? buf_q[31:16] : buf_q[15:0];
    end else begin : g_full
      assign ok   = valid_q && (tag_q == addr);
      assign data = buf_q;
    end
  endgenerate

  assign pending = !ok && !busy_q;

endmodule

// File: rtl/jts16_gfx_rom.sv
// SDRAM-side responder for the System 16 video fetch ports: five cached slots
// sharing one SDRAM read channel through a fixed-priority arbiter.
module jts16_gfx_rom
  import jts16_rom_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = 22'h0,
  parameter logic [21:0] MAP1_OFFSET = 22'h0,
  parameter logic [21:0] MAP2_OFFSET = 22'h0,
  parameter logic [21:0] SCR_OFFSET  = 22'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] char_addr,
  output logic        char_ok,
  output logic [31:0] char_data,
  input  logic [14:0] map1_addr,
  output logic        map1_ok,
  output logic [15:0] map1_data,
  input  logic [14:0] map2_addr,
  output logic        map2_ok,
  output logic [15:0] map2_data,
  input  logic [16:0] scr1_addr,
  output logic        scr1_ok,
  output logic [31:0] scr1_data,
  input  logic [16:0] scr2_addr,
  output logic        scr2_ok,
  output logic [31:0] scr2_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_data
);

  state_t            state_q, state_d;
  logic [NSLOT-1:0]  pending, set_busy, wr;
  logic [21:0]       req_addr [NSLOT];
  logic [16:0]       req_tag  [NSLOT];
  logic [2:0]        win_idx, win_q;
  logic [21:0]       win_addr;
  logic [16:0]       win_tag, tag_q;
  logic              grant;

  // Map ports fetch the aligned pair, so address bit 0 is dropped here.
  assign req_addr[CHAR] = word_addr(CHAR_OFFSET, {8'd0, char_addr});
  assign req_addr[SCR1] = word_addr(SCR_OFFSET,  {4'd0, scr1_addr});
  assign req_addr[SCR2] = word_addr(SCR_OFFSET,  {4'd0, scr2_addr});
  assign req_addr[MAP1] = word_addr(MAP1_OFFSET, {7'd0, map1_addr[14:1]});
  assign req_addr[MAP2] = word_addr(MAP2_OFFSET, {7'd0, map2_addr[14:1]});

  assign req_tag[CHAR] = {4'd0, char_addr};
  assign req_tag[SCR1] = scr1_addr;
  assign req_tag[SCR2] = scr2_addr;
  assign req_tag[MAP1] = {2'd0, map1_addr};
  assign req_tag[MAP2] = {2'd0, map2_addr};

  // Scanning from the lowest priority up lets the highest pending slot win.
  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a variable
    // unassigned and no latch is inferred.
    win_idx  = '0;
    win_addr = '0;
    win_tag  = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx  = 3'(i);
        win_addr = req_addr[i];
        win_tag  = req_tag[i];
      end
    end
  end

  assign grant = (state_q == IDLE) && (|pending);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending) state_d = REQ;
      REQ:     if (sdram_ack) state_d = WAIT;
      WAIT:    if (sdram_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      tag_q      <= '0;
      sdram_addr <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q      <= win_idx;
        tag_q      <= win_tag;
        sdram_addr <= win_addr;
      end
    end
  end

  assign sdram_req = (state_q == REQ);
  assign set_busy  = grant ? (NSLOT'(1) << win_idx) : '0;
  assign wr        = ((state_q == WAIT) && sdram_rdy) ? (NSLOT'(1) << win_q) : '0;

  jts16_rom_slot #(.AW(13), .IS16(1'b0)) u_char (
    .clk, .rst_n, .addr(char_addr), .set_busy(set_busy[CHAR]), .wr(wr[CHAR]),
    .wr_tag(tag_q[12:0]), .wr_data(sdram_data), .ok(char_ok),
    .pending(pending[CHAR]), .data(char_data)
  );

  jts16_rom_slot #(.AW(17), .IS16(1'b0)) u_scr1 (
    .clk, .rst_n, .addr(scr1_addr), .set_busy(set_busy[SCR1]), .wr(wr[SCR1]),
    .wr_tag(tag_q), .wr_data(sdram_data), .ok(scr1_ok),
    .pending(pending[SCR1]), .data(scr1_data)
  );

  jts16_rom_slot #(.AW(17), .IS16(1'b0)) u_scr2 (
    .clk, .rst_n, .addr(scr2_addr), .set_busy(set_busy[SCR2]), .wr(wr[SCR2]),
    .wr_tag(tag_q), .wr_data(sdram_data), .ok(scr2_ok),
    .pending(pending[SCR2]), .data(scr2_data)
  );

  jts16_rom_slot #(.AW(15), .IS16(1'b1)) u_map1 (
    .clk, .rst_n, .addr(map1_addr), .set_busy(set_busy[MAP1]), .wr(wr[MAP1]),
    .wr_tag(tag_q[14:0]), .wr_data(sdram_data), .ok(map1_ok),
    .pending(pending[MAP1]), .data(map1_data)
  );

  jts16_rom_slot #(.AW(15), .IS16(1'b1)) u_map2 (
    .clk, .rst_n, .addr(map2_addr), .set_busy(set_busy[MAP2]), .wr(wr[MAP2]),
    .wr_tag(tag_q[14:0]), .wr_data(sdram_data), .ok(map2_ok),
    .pending(pending[MAP2]), .data(map2_data)
  );

endmodule
